spi_cmd_decoder: RTL and testbench

- Sits directly downstream of the SPI byte-receive stage, which presents a parallel byte plus a "byte changed" flag.
- Turns the byte stream of each chip-select frame into register-file write strobes and read requests.
- The first byte of a frame is a command (direction + start address). Each later byte is one data slot, and the address auto-increments per slot.
- Runs on the system clock. SPI-domain inputs are synchronised internally.

---
 rtl/spi_cmd_decoder.sv | 199 +++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns the byte stream of each SPI chip-select frame into
// register-file write strobes and read requests. The first byte of a frame is
// a command (bit 7 = write, low bits = start address); every later byte is one
// data slot with the address auto-incrementing. SPI-domain flags are
// synchronised into CLK.
//
// Optional build macro: SPI_DEC_ERR_EN adds an ERR pulse output for frames
// closed without data slots and for address wrap inside a frame.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | chip select high, no frame in progress
// CMD   | frame open, waiting for the command byte
// WRITE | each received byte becomes a write at the running address
// READ  | each received byte is a dummy; request next read address

module spi_cmd_decoder #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SPI_CS,
    input  logic              SPI_CHANGED,
    input  logic [7:0]        SPI_BYTE,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] RD_ADDR,
`ifdef SPI_DEC_ERR_EN
    output logic              ERR,
`endif
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] chg_sync;
    logic                   chg_prev;
    logic                   cs_s;
    logic                   strobe;

    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] addr_inc;
    logic              addr_at_max;

    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt;
    logic              rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

`ifdef SPI_DEC_ERR_EN
    logic got_slot, got_slot_nxt;
    logic err_nxt;
`endif

    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign strobe      = chg_sync[SYNC_STAGES-1] & ~chg_prev;
    assign addr_inc    = addr + 1'b1;
    assign addr_at_max = &addr;

    // Synchronise chip select and byte flag; keep previous flag for edge detect.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync  <= '0;
            chg_sync <= '0;
            chg_prev <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            chg_sync <= {chg_sync[SYNC_STAGES-2:0], SPI_CHANGED};
            chg_prev <= chg_sync[SYNC_STAGES-1];
        end
    end

    // State, address counter and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            addr    <= '0;
            WR_EN   <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            RD_EN   <= 1'b0;
            RD_ADDR <= '0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            WR_EN   <= wr_en_nxt;
            WR_ADDR <= wr_addr_nxt;
            WR_DATA <= wr_data_nxt;
            RD_EN   <= rd_en_nxt;
            RD_ADDR <= rd_addr_nxt;
            BUSY    <= (state_nxt != IDLE);
        end
    end

`ifdef SPI_DEC_ERR_EN
    // Error pulse register and "frame has seen a data slot" flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR      <= 1'b0;
            got_slot <= 1'b0;
        end else begin
            ERR      <= err_nxt;
            got_slot <= got_slot_nxt;
        end
    end
`endif

    // Next-state and next-output decode; CS high overrides any strobe.
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = WR_ADDR;
        wr_data_nxt = WR_DATA;
        rd_en_nxt   = 1'b0;
        rd_addr_nxt = RD_ADDR;
`ifdef SPI_DEC_ERR_EN
        err_nxt      = 1'b0;
        got_slot_nxt = got_slot;
`endif
        if (cs_s) begin
            state_nxt = IDLE;
`ifdef SPI_DEC_ERR_EN
            if (state == CMD)
                err_nxt = 1'b1;
            else if ((state == WRITE || state == READ) && !got_slot)
                err_nxt = 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = CMD;
                end
                CMD: begin
                    if (strobe) begin
                        addr_nxt = SPI_BYTE[ADDR_W-1:0];
`ifdef SPI_DEC_ERR_EN
                        got_slot_nxt = 1'b0;
`endif
                        if (SPI_BYTE[7]) begin
                            state_nxt = WRITE;
                        end else begin
                            // Prefetch the first read slot straight away.
                            state_nxt   = READ;
                            rd_en_nxt   = 1'b1;
                            rd_addr_nxt = SPI_BYTE[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (strobe) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = addr;
                        wr_data_nxt = SPI_BYTE;
                        addr_nxt    = addr_inc;
`ifdef SPI_DEC_ERR_EN
                        got_slot_nxt = 1'b1;
                        err_nxt      = addr_at_max;
`endif
                    end
                end
                READ: begin
                    if (strobe) begin
                        addr_nxt    = addr_inc;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = addr_inc;
`ifdef SPI_DEC_ERR_EN
                        got_slot_nxt = 1'b1;
                        err_nxt      = addr_at_max;
`endif
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Keeps the wrap detector referenced in builds without the error output.
`ifndef SPI_DEC_ERR_EN
    logic unused_ok;
    assign unused_ok = addr_at_max;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: write/read bursts, latency, wrap,
// CS-priority abort and asynchronous reset mid-frame.

module tb_spi_cmd_decoder;

    logic       CLK;
    logic       RST_N;
    logic       SPI_CS;
    logic       SPI_CHANGED;
    logic [7:0] SPI_BYTE;
    logic       WR_EN;
    logic [6:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       RD_EN;
    logic [6:0] RD_ADDR;
    logic       BUSY;
`ifdef SPI_DEC_ERR_EN
    logic       ERR;
    int         err_cnt;
`endif

    int n_chk;
    int n_pass;

    logic [14:0] wr_q[$];
    logic [6:0]  rd_q[$];

    spi_cmd_decoder dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SPI_CS      (SPI_CS),
        .SPI_CHANGED (SPI_CHANGED),
        .SPI_BYTE    (SPI_BYTE),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .RD_EN       (RD_EN),
        .RD_ADDR     (RD_ADDR),
`ifdef SPI_DEC_ERR_EN
        .ERR         (ERR),
`endif
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every strobe/request one step after the clock edge.
    always @(posedge CLK) begin
        #1;
        if (WR_EN) wr_q.push_back({WR_ADDR, WR_DATA});
        if (RD_EN) rd_q.push_back(RD_ADDR);
`ifdef SPI_DEC_ERR_EN
        if (ERR) err_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_q.delete();
`ifdef SPI_DEC_ERR_EN
        err_cnt = 0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge CLK);
        SPI_BYTE    = b;
        SPI_CHANGED = 1'b1;
        repeat (hold) @(negedge CLK);
        SPI_CHANGED = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic open_frame();
        @(negedge CLK);
        SPI_CS = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic close_frame();
        @(negedge CLK);
        SPI_CS   = 1'b1;
        SPI_BYTE = 8'hFF;
        repeat (5) @(negedge CLK);
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        RST_N       = 1'b0;
        SPI_CS      = 1'b1;
        SPI_CHANGED = 1'b0;
        SPI_BYTE    = 8'hFF;
`ifdef SPI_DEC_ERR_EN
        err_cnt     = 0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wr_en",   {31'd0, WR_EN}, 32'd0);
        chk("rst_rd_en",   {31'd0, RD_EN}, 32'd0);
        chk("rst_busy",    {31'd0, BUSY},  32'd0);
        chk("rst_wr_addr", {25'd0, WR_ADDR}, 32'd0);
        chk("rst_wr_data", {24'd0, WR_DATA}, 32'd0);
        chk("rst_rd_addr", {25'd0, RD_ADDR}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        // Write burst 0x83, 0xAA, 0xBB with latency check and long flag hold.
        open_frame();
        chk("cmd_busy", {31'd0, BUSY}, 32'd1);
        clear_logs();
        send_byte(8'h83, 10);
        @(negedge CLK);
        SPI_BYTE    = 8'hAA;
        SPI_CHANGED = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        chk("lat_edge2_wr_en", {31'd0, WR_EN}, 32'd0);
        @(posedge CLK); #1;
        chk("lat_edge3_wr_en", {31'd0, WR_EN}, 32'd1);
        chk("lat_wr_addr", {25'd0, WR_ADDR}, 32'h03);
        chk("lat_wr_data", {24'd0, WR_DATA}, 32'hAA);
        repeat (8) @(negedge CLK);
        SPI_CHANGED = 1'b0;
        repeat (4) @(negedge CLK);
        send_byte(8'hBB, 10);
        chk("wr_burst_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("wr_burst_0", {17'd0, wr_q[0]}, {17'd0, 7'h03, 8'hAA});
            chk("wr_burst_1", {17'd0, wr_q[1]}, {17'd0, 7'h04, 8'hBB});
        end
        chk("wr_burst_no_rd", rd_q.size(), 0);
        close_frame();
        chk("wr_close_busy", {31'd0, BUSY}, 32'd0);
`ifdef SPI_DEC_ERR_EN
        chk("wr_burst_err", err_cnt, 0);
`endif

        // Read burst 0x10, 0x00, 0x00.
        open_frame();
        clear_logs();
        send_byte(8'h10, 3);
        send_byte(8'h00, 3);
        send_byte(8'h00, 3);
        chk("rd_burst_count", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            chk("rd_burst_0", {25'd0, rd_q[0]}, 32'h10);
            chk("rd_burst_1", {25'd0, rd_q[1]}, 32'h11);
            chk("rd_burst_2", {25'd0, rd_q[2]}, 32'h12);
        end
        chk("rd_burst_no_wr", wr_q.size(), 0);
        close_frame();

        // Address wrap: write at 0x7F then 0x00.
        open_frame();
        clear_logs();
        send_byte(8'hFF, 3);
        send_byte(8'h11, 3);
        send_byte(8'h22, 3);
        chk("wrap_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("wrap_0", {17'd0, wr_q[0]}, {17'd0, 7'h7F, 8'h11});
            chk("wrap_1", {17'd0, wr_q[1]}, {17'd0, 7'h00, 8'h22});
        end
`ifdef SPI_DEC_ERR_EN
        chk("wrap_err", err_cnt, 1);
`endif
        close_frame();

        // CS rises together with the first data byte: strobe must be dropped.
        open_frame();
        clear_logs();
        send_byte(8'h81, 3);
        @(negedge CLK);
        SPI_BYTE    = 8'h5A;
        SPI_CHANGED = 1'b1;
        SPI_CS      = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        chk("abort_busy_pre", {31'd0, BUSY}, 32'd1);
        @(posedge CLK); #1;
        chk("abort_busy_post", {31'd0, BUSY}, 32'd0);
        chk("abort_wr_en", {31'd0, WR_EN}, 32'd0);
        repeat (3) @(negedge CLK);
        SPI_CHANGED = 1'b0;
        SPI_BYTE    = 8'hFF;
        repeat (4) @(negedge CLK);
        chk("abort_no_wr", wr_q.size(), 0);
        chk("abort_idle_busy", {31'd0, BUSY}, 32'd0);
`ifdef SPI_DEC_ERR_EN
        chk("abort_err", err_cnt, 1);
`endif

        // Asynchronous reset mid-frame, then a fresh command with CS still low.
        open_frame();
        clear_logs();
        send_byte(8'h85, 3);
        chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_busy",  {31'd0, BUSY},  32'd0);
        chk("async_rst_wr_en", {31'd0, WR_EN}, 32'd0);
        chk("async_rst_rd_en", {31'd0, RD_EN}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        chk("post_rst_busy", {31'd0, BUSY}, 32'd1);
        send_byte(8'h02, 3);
        send_byte(8'h55, 3);
        chk("post_rst_rd_count", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            chk("post_rst_rd_0", {25'd0, rd_q[0]}, 32'h02);
            chk("post_rst_rd_1", {25'd0, rd_q[1]}, 32'h03);
        end
        chk("post_rst_no_wr", wr_q.size(), 0);
        close_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
